// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared types, sizes and header byte-swap helpers for packet_builder
//
// Purpose: FSM state enum, header/payload sizing constants, field widths and the
// byte-swap functions that put header fields on the wire low byte first.
// Ports: none (package).

package pkt_pkg;

    localparam int HDR_BYTES   = 8;
    localparam int MAX_PAYLOAD = 36;
    localparam int STREAM_W    = 4;
    localparam int WIRE_ID_W   = 16;
    localparam int SEQ_W       = 32;
    localparam int LEN_W       = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_e;

    // Header fields travel least-significant byte first inside a big-endian word.
    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - per-stream 32-bit sequence counters with one read and one increment port
//
// Purpose: holds an independent sequence number per stream; combinational read,
// registered increment (wraps modulo 2^SEQ_W).
// Ports:
//   clk        - clock
//   reset_b    - asynchronous active-low reset, clears every counter
//   rd_idx_i   - stream index to read
//   rd_data_o  - current counter of rd_idx_i
//   inc_i      - increment strobe
//   inc_idx_i  - stream index to increment

module seq_table #(
    parameter int NUM_STREAMS = 16,
    parameter int IDX_W       = 4,
    parameter int SEQ_W       = 32
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [SEQ_W-1:0] rd_data_o,
    input  logic             inc_i,
    input  logic [IDX_W-1:0] inc_idx_i
);

    logic [SEQ_W-1:0] cnt_q [NUM_STREAMS];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_i) begin
            cnt_q[inc_idx_i] <= cnt_q[inc_idx_i] + SEQ_W'(1);
        end
    end

    assign rd_data_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/packet_builder.sv
// rtl/packet_builder.sv - serialises message descriptors into 32-bit header+payload packet words
//
// Purpose: accepts one descriptor in IDLE, then emits HDR0 (length, stream ID),
// HDR1 (per-stream sequence number) and ceil(len/4) payload words, with a
// valid/ready handshake on the output. Oversized descriptors are dropped with
// a one-cycle lenError pulse.
// Ports:
//   clk, reset_b            - clock, asynchronous active-low reset
//   msgIn_val/msgIn_ready   - descriptor handshake
//   msgIn_stream            - 4-bit stream index
//   msgIn_len               - payload byte count
//   msgIn_data              - payload, byte b at bits [8b:8b+7]
//   dataOut/_val/_ready/_last - output word stream
//   lenError                - pulse after an illegal-length descriptor is dropped

module packet_builder #(
    parameter int MAX_PAYLOAD = pkt_pkg::MAX_PAYLOAD,
    parameter int NUM_STREAMS = 16
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic                          msgIn_val,
    output logic                          msgIn_ready,
    input  logic [pkt_pkg::STREAM_W-1:0]  msgIn_stream,
    input  logic [pkt_pkg::LEN_W-1:0]     msgIn_len,
    input  logic [0:8*MAX_PAYLOAD-1]      msgIn_data,
    output logic [31:0]                   dataOut,
    output logic                          dataOut_val,
    input  logic                          dataOut_ready,
    output logic                          dataOut_last,
    output logic                          lenError
);

    import pkt_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_e                    state_q, state_d;
    logic                      live_q;
    logic                      len_err_q;
    logic [STREAM_W-1:0]       stream_q;
    logic [LEN_W-1:0]          len_q;
    logic [0:8*MAX_PAYLOAD-1]  data_q;
    logic [SEQ_W-1:0]          seq_q;
    logic [3:0]                widx_q, widx_d;

    logic                      accept;
    logic                      drop;
    logic                      seq_inc;
    logic [SEQ_W-1:0]          seq_rd;
    logic [15:0]               hdr_len;
    logic [WIRE_ID_W-1:0]      wire_id;
    logic [3:0]                last_idx;
    logic [31:0]               raw_word;
    logic [31:0]               pay_word;

    seq_table #(
        .NUM_STREAMS(NUM_STREAMS),
        .IDX_W      (STREAM_W),
        .SEQ_W      (SEQ_W)
    ) u_seq_table (
        .clk      (clk),
        .reset_b  (reset_b),
        .rd_idx_i (msgIn_stream),
        .rd_data_o(seq_rd),
        .inc_i    (seq_inc),
        .inc_idx_i(stream_q)
    );

    assign hdr_len  = 16'(len_q) + 16'(HDR_BYTES);
    assign wire_id  = WIRE_ID_W'(stream_q);
    // Index of the final payload word: ceil(len/4) - 1.
    assign last_idx = len_q[5:2] + {3'b000, |len_q[1:0]} - 4'd1;
    assign raw_word = data_q[{widx_q, 5'd0} +: 32];

    // Bytes past the message length are zeroed rather than leaking stale data.
    always_comb begin
        pay_word = '0;
        for (int i = 0; i < 4; i++) begin
            if ({widx_q, 2'(i)} < len_q) begin
                pay_word[31-8*i -: 8] = raw_word[31-8*i -: 8];
            end
        end
    end

    // live_q holds msgIn_ready low until the first clock edge after reset release.
    assign msgIn_ready = live_q && (state_q == IDLE);
    assign lenError    = len_err_q;

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        accept       = 1'b0;
        drop         = 1'b0;
        seq_inc      = 1'b0;
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (live_q && msgIn_val) begin
                    if (msgIn_len <= MAX_LEN) begin
                        accept  = 1'b1;
                        widx_d  = '0;
                        state_d = HDR0;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            HDR0: begin
                dataOut_val = 1'b1;
                dataOut     = {swap16(hdr_len), swap16(wire_id)};
                if (dataOut_ready) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                dataOut_val  = 1'b1;
                dataOut      = swap32(seq_q);
                dataOut_last = (len_q == '0);
                if (dataOut_ready) begin
                    if (len_q == '0) begin
                        state_d = IDLE;
                        seq_inc = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                dataOut_val  = 1'b1;
                dataOut      = pay_word;
                dataOut_last = (widx_q == last_idx);
                if (dataOut_ready) begin
                    if (widx_q == last_idx) begin
                        state_d = IDLE;
                        seq_inc = 1'b1;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            len_err_q <= 1'b0;
            stream_q  <= '0;
            len_q     <= '0;
            data_q    <= '0;
            seq_q     <= '0;
            widx_q    <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            live_q    <= 1'b1;
            len_err_q <= drop;
            if (accept) begin
                stream_q <= msgIn_stream;
                len_q    <= msgIn_len;
                data_q   <= msgIn_data;
                seq_q    <= seq_rd;
            end
        end
    end

endmodule

// File: tb/tb_packet_builder.sv
// tb/tb_packet_builder.sv - self-checking bench for packet_builder

module tb_packet_builder;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          msgIn_val;
    logic          msgIn_ready;
    logic [3:0]    msgIn_stream;
    logic [5:0]    msgIn_len;
    logic [0:287]  msgIn_data;
    logic [31:0]   dataOut;
    logic          dataOut_val;
    logic          dataOut_ready;
    logic          dataOut_last;
    logic          lenError;

    int total = 0;
    int bad   = 0;

    word_t       exp_q[$];
    word_t       obs[$];
    logic [31:0] seq_m [16];
    logic        live    = 1'b0;
    logic        err_due = 1'b0;
    int          lenerr_seen = 0;

    packet_builder #(
        .MAX_PAYLOAD(36),
        .NUM_STREAMS(16)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .msgIn_val    (msgIn_val),
        .msgIn_ready  (msgIn_ready),
        .msgIn_stream (msgIn_stream),
        .msgIn_len    (msgIn_len),
        .msgIn_data   (msgIn_data),
        .dataOut      (dataOut),
        .dataOut_val  (dataOut_val),
        .dataOut_ready(dataOut_ready),
        .dataOut_last (dataOut_last),
        .lenError     (lenError)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Model: lay out the packet as a byte string, then cut it into big-endian words.
    function automatic void model_push(input int stream, input int len, input int base);
        logic [7:0]  b[$];
        logic [31:0] q;
        int          hl;
        int          nw;
        word_t       e;
        hl = len + 8;
        q  = seq_m[stream];
        b.push_back(8'(hl & 255));
        b.push_back(8'((hl >> 8) & 255));
        b.push_back(8'(stream & 255));
        b.push_back(8'((stream >> 8) & 255));
        for (int i = 0; i < 4; i++) b.push_back(8'((q >> (8 * i)) & 32'hFF));
        for (int i = 0; i < len; i++) b.push_back(8'((base + i) & 255));
        while (b.size() % 4 != 0) b.push_back(8'h00);
        nw = b.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.w    = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            e.last = (w == nw - 1);
            exp_q.push_back(e);
        end
        seq_m[stream] = seq_m[stream] + 32'd1;
    endfunction

    always @(negedge clk) begin
        if (!reset_b) begin
            chk("rst_val", dataOut_val, 0);
            chk("rst_ready", msgIn_ready, 0);
            chk("rst_data", dataOut, 0);
            chk("rst_last", dataOut_last, 0);
            chk("rst_lenerr", lenError, 0);
        end else begin
            chk("ready", msgIn_ready, live && exp_q.size() == 0);
            chk("val", dataOut_val, exp_q.size() != 0);
            chk("lenerr", lenError, err_due);
            if (lenError) lenerr_seen++;
            err_due = 1'b0;
            if (dataOut_val && exp_q.size() != 0) begin
                chk("word", dataOut, exp_q[0].w);
                chk("last", dataOut_last, exp_q[0].last);
                if (dataOut_ready) begin
                    obs.push_back('{w: dataOut, last: dataOut_last});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int stream, input int len, input int base);
        logic [0:287] d;
        int n;
        @(posedge clk);
        #1;
        for (int b = 0; b < 36; b++) d[8*b +: 8] = 8'((base + b) & 255);
        msgIn_stream = 4'(stream);
        msgIn_len    = 6'(len);
        msgIn_data   = d;
        msgIn_val    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!msgIn_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", msgIn_ready, 1);
        @(posedge clk);
        #1;
        msgIn_val = 1'b0;
        if (len > 36) err_due = 1'b1;
        else model_push(stream, len, base);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        chk(name, exp_q.size(), 0);
        @(posedge clk);
    endtask

    task automatic wait_obs(input string name, input int target);
        for (int n = 0; n < 100 && obs.size() < target; n++) @(posedge clk);
        chk(name, obs.size() >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        int e0;
        reset_b       = 1'b0;
        msgIn_val     = 1'b0;
        msgIn_stream  = '0;
        msgIn_len     = '0;
        msgIn_data    = '0;
        dataOut_ready = 1'b1;
        for (int i = 0; i < 16; i++) seq_m[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", msgIn_ready, 0);
        chk("reset_val", dataOut_val, 0);
        @(posedge clk);
        #2 reset_b = 1'b1;
        @(posedge clk);
        #1 live = 1'b1;

        // stream 12, len 12, bytes 0x01..0x0C
        s = obs.size();
        send(12, 12, 1);
        wait_idle("A_drain");
        chk("A_cnt", obs.size() - s, 5);
        chk("A_w0", obs[s].w, 32'h14000C00);
        chk("A_w1", obs[s+1].w, 32'h00000000);
        chk("A_w2", obs[s+2].w, 32'h01020304);
        chk("A_w3", obs[s+3].w, 32'h05060708);
        chk("A_w4", obs[s+4].w, 32'h090A0B0C);
        chk("A_last3", obs[s+3].last, 0);
        chk("A_last4", obs[s+4].last, 1);

        // second stream-12 packet, then stream 14
        s = obs.size();
        send(12, 12, 32);
        send(14, 4, 64);
        wait_idle("BC_drain");
        chk("BC_cnt", obs.size() - s, 8);
        chk("B_hdr1", obs[s+1].w, 32'h01000000);
        chk("C_hdr0", obs[s+5].w, 32'h0C000E00);
        chk("C_hdr1", obs[s+6].w, 32'h00000000);
        chk("C_pay", obs[s+7].w, 32'h40414243);

        // len 13: last word has a single valid byte
        s = obs.size();
        send(3, 13, 1);
        wait_idle("D_drain");
        chk("D_cnt", obs.size() - s, 6);
        chk("D_w5", obs[s+5].w, 32'h0D000000);
        chk("D_last5", obs[s+5].last, 1);

        // len 0: header only, last on HDR1
        s = obs.size();
        send(12, 0, 1);
        wait_idle("E_drain");
        chk("E_cnt", obs.size() - s, 2);
        chk("E_hdr0", obs[s].w, 32'h08000C00);
        chk("E_hdr1", obs[s+1].w, 32'h02000000);
        chk("E_last0", obs[s].last, 0);
        chk("E_last1", obs[s+1].last, 1);

        // max length with a 7-cycle stall mid-payload
        s = obs.size();
        send(5, 36, 128);
        wait_obs("F_reach", s + 4);
        #1 dataOut_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 dataOut_ready = 1'b1;
        wait_idle("F_drain");
        chk("F_cnt", obs.size() - s, 11);
        chk("F_w10", obs[s+10].w, 32'hA0A1A2A3);
        chk("F_last10", obs[s+10].last, 1);

        // len 37 dropped; sequence unchanged
        e0 = lenerr_seen;
        s  = obs.size();
        send(12, 37, 1);
        repeat (3) @(posedge clk);
        chk("G_pulses", lenerr_seen - e0, 1);
        chk("G_noout", obs.size() - s, 0);
        send(12, 4, 16);
        wait_idle("G_drain");
        chk("G_hdr1", obs[s+1].w, 32'h03000000);
        chk("G_cnt", obs.size() - s, 3);

        // reset pulse while HDR1 is on the bus
        s = obs.size();
        send(12, 8, 1);
        wait_obs("H_reach", s + 1);
        #2;
        reset_b = 1'b0;
        live    = 1'b0;
        err_due = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) seq_m[i] = '0;
        #1;
        chk("H_val_now", dataOut_val, 0);
        chk("H_ready_now", msgIn_ready, 0);
        repeat (2) @(posedge clk);
        #2 reset_b = 1'b1;
        @(posedge clk);
        #1 live = 1'b1;
        chk("H_abort_cnt", obs.size() - s, 1);
        s = obs.size();
        send(12, 4, 1);
        wait_idle("H_drain");
        chk("H_hdr1", obs[s+1].w, 32'h00000000);
        chk("H_w2", obs[s+2].w, 32'h01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_builder.md
PACKET_BUILDER -- requirements
Module: packet_builder

Interface
REQ-001 Parameter MAX_PAYLOAD, default 36: maximum payload bytes per message.
REQ-002 Parameter NUM_STREAMS, default 16: number of streams with independent sequence counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_b  input  1  asynchronous, active-low reset.
REQ-005 msgIn_val  input  1  message descriptor valid.
REQ-006 msgIn_ready  output  1  builder can accept a descriptor.
REQ-007 msgIn_stream  input  4  stream index; zero-extended to the 16-bit wire stream ID.
REQ-008 msgIn_len  input  6  payload byte count, 0..MAX_PAYLOAD.
REQ-009 msgIn_data  input  288 [0:287]  payload; byte b occupies bits [8b:8b+7].
REQ-010 dataOut  output  32  serialized packet word.
REQ-011 dataOut_val  output  1  dataOut valid.
REQ-012 dataOut_ready  input  1  downstream accepts the word.
REQ-013 dataOut_last  output  1  final word of the packet.
REQ-014 lenError  output  1  one-cycle pulse when a descriptor is dropped for an illegal length.

Function
REQ-015 The builder SHALL use states IDLE, HDR0, HDR1 and PAYLOAD; msgIn_ready SHALL equal (state==IDLE).
REQ-016 In IDLE, when msgIn_val is high and msgIn_len<=MAX_PAYLOAD, the builder SHALL register stream, len, data and the stream's current sequence number, and go to HDR0.
REQ-017 In IDLE, when msgIn_val is high and msgIn_len>MAX_PAYLOAD, the builder SHALL drop the descriptor, pulse lenError the next cycle, stay in IDLE, and leave the sequence counters unchanged.
REQ-018 Header length L = msgIn_len+8 (16 bits); word count W = 2+ceil(msgIn_len/4).
REQ-019 HDR0 word: dataOut = {L[7:0], L[15:8], S[7:0], S[15:8]}, where S is the 16-bit stream ID.
REQ-020 HDR1 word: dataOut = {Q[7:0], Q[15:8], Q[23:16], Q[31:24]}, where Q is the 32-bit sequence number.
REQ-021 PAYLOAD word k (k=0..): dataOut[31:24] = byte 4k, [23:16] = byte 4k+1, [15:8] = byte 4k+2, [7:0] = byte 4k+3; bytes at or beyond len SHALL be driven zero.
REQ-022 dataOut_val SHALL be high in HDR0, HDR1 and PAYLOAD, and low in IDLE.
REQ-023 The state and word index SHALL advance only on dataOut_val && dataOut_ready.
REQ-024 dataOut and dataOut_last SHALL be held stable while dataOut_val is high and dataOut_ready is low.
REQ-025 dataOut_last SHALL be high on word W-1 only; for len=0 it SHALL be high on the HDR1 word, and the PAYLOAD state SHALL be skipped.
REQ-026 On the handshake of the last word, the state SHALL return to IDLE and the stream's sequence counter SHALL increment modulo 2^32.
REQ-027 The minimum gap between packets SHALL be one IDLE cycle; latency SHALL be one cycle from the descriptor handshake to the first dataOut_val.
REQ-028 Sequence counters SHALL be independent per stream; a packet on one stream SHALL never alter another stream's counter.

Reset
REQ-029 While reset_b is low, the following SHALL be forced: state=IDLE, dataOut_val=0, dataOut_last=0, dataOut=0, lenError=0, msgIn_ready=0, all sequence counters=0.
REQ-030 Assertion of reset mid-packet SHALL abandon the packet without a last word; after release, msgIn_ready SHALL go high on the first clock edge.

Structure
REQ-031 A shared package pkt_pkg SHALL hold the state enum, HDR_BYTES=8, MAX_PAYLOAD, the stream and sequence widths, and the header byte-swap functions.
REQ-032 The per-stream counters SHALL be a sub-module seq_table with ports: read index, read data, increment strobe, increment index.

Verification
REQ-033 Stream 12, len 12, payload 0x01..0x0C, dataOut_ready held high -> the bench SHALL see 5 words: 0x14000C00, 0x00000000, 0x01020304, 0x05060708, 0x090A0B0C, with last on word 5.
REQ-034 A second stream-12 packet, followed by a stream-14 packet -> the HDR1 words SHALL be 0x01000000 and 0x00000000 respectively.
REQ-035 Len 13 -> 6 words; word 5 SHALL be 0x0D000000 (only byte 12 valid), with last on word 5; len 0 -> 2 words, with last on HDR1 and header word 0x08000C00.
REQ-036 dataOut_ready low for 7 cycles in the middle of the payload -> dataOut SHALL be held constant, no word SHALL be lost or duplicated, and msgIn_ready SHALL stay low.
REQ-037 Len 37 -> lenError SHALL pulse once, no dataOut_val SHALL occur, and the next valid packet on the same stream SHALL carry the unchanged sequence number.
REQ-038 reset_b pulsed low during HDR1 -> dataOut_val SHALL be 0 immediately, and the next packet SHALL start with sequence number 0.
